aer_decoder: RTL and testbench

- Receiving end of the neuron-layer AER link. Takes the serialized address-event bus plus its frame-enable, and rebuilds the per-timestep spike vector.
- Accumulates the events of one frame and closes the frame when the encoder's enable falls, or on timeout.
- Hands the vector to the next layer through a one-deep valid/ready output buffer, with error and overrun flags.

---
 rtl/snn_aer_pkg.sv | 25 ++
 rtl/aer_frame_buffer.sv | 47 ++++
 rtl/aer_decoder.sv | 143 ++++++++++++++
 tb/tb_aer_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_aer_pkg.sv
// Shared definitions for the AER link: address width, valid-bit position
// and the decoder's frame-assembly state encoding.
package snn_aer_pkg;

   // Address field width needed to name n neurons (never narrower than 1 bit).
   function automatic int aer_addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // The event-valid flag sits directly above the address field.
   function automatic int aer_valid_bit(input int n);
      return aer_addr_w(n);
   endfunction

   // Valid-bit position for the default 10-neuron layer.
   localparam int AER_DEFAULT_N         = 10;
   localparam int AER_DEFAULT_VALID_BIT = aer_valid_bit(AER_DEFAULT_N);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      CLOSE   = 2'd2
   } aer_state_t;

endpackage

// File: rtl/aer_frame_buffer.sv
// One-deep output register for finished frames. A load arriving while an
// unconsumed frame is held (and not being consumed this cycle) is dropped
// and reported through the overrun pulse.
module aer_frame_buffer #(
   parameter int N  = 10,
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [N-1:0]  load_spikes,
   input  logic [CW-1:0] load_count,
   input  logic          ready,
   output logic [N-1:0]  spikes,
   output logic [CW-1:0] count,
   output logic          valid,
   output logic          overrun
);

   // Handshake: a frame transfers on a clock edge where valid && ready are
   // both high; valid never drops without a transfer, and spikes/count stay
   // stable while valid is high and only change when a new frame loads.

   logic can_load;

   // Room exists when empty or when the held frame leaves on this edge.
   always_comb begin
      can_load = !valid || ready;
      overrun  = load && !can_load;
   end

   // Output register: reload on an accepted close, otherwise retire on handshake.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         spikes <= '0;
         count  <= '0;
         valid  <= 1'b0;
      end else if (load && can_load) begin
         spikes <= load_spikes;
         count  <= load_count;
         valid  <= 1'b1;
      end else if (valid && ready) begin
         valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/aer_decoder.sv
// Receiving end of the AER link: collects address events into a spike
// vector per frame, closes the frame on the falling edge of aer_enable or
// on timeout, and hands the vector on through a one-deep output buffer.
module aer_decoder
   import snn_aer_pkg::*;
#(
   parameter int  no_of_neurons = 10,
   parameter int  frame_timeout = 64,
   localparam int AW            = aer_addr_w(no_of_neurons)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [AW:0]              aer_bus,
   input  logic                     aer_enable,
   output logic [no_of_neurons-1:0] spikes_out,
   output logic                     spikes_valid,
   input  logic                     spikes_ready,
   output logic [AW:0]              event_count,
   output logic                     err_addr,
   output logic                     err_dup,
   output logic                     err_overrun,
   output logic                     err_timeout,
   output aer_state_t               dbg_state
);

   localparam int              VB      = aer_valid_bit(no_of_neurons);
   localparam int              TW      = (frame_timeout > 1) ? $clog2(frame_timeout) : 1;
   localparam logic [TW-1:0]   TO_LAST = TW'((frame_timeout > 0) ? frame_timeout - 1 : 0);
   localparam logic [AW:0]     N_SAT   = (AW+1)'(no_of_neurons);

   aer_state_t               state, state_nxt;
   logic [no_of_neurons-1:0] acc, acc_base, acc_nxt;
   logic [AW:0]              cnt, cnt_base, cnt_nxt;
   logic [TW-1:0]            to_cnt;
   logic                     enable_q;
   logic                     ev_valid, addr_ok, ev_dup, ev_new;
   logic [AW-1:0]            ev_addr;
   logic                     fall, to_hit;
   logic                     close_load, timeout_evt, buf_overrun;

   // Event decode; in CLOSE the accumulator is treated as already cleared so
   // an event arriving then starts the next frame.
   always_comb begin
      ev_valid = aer_bus[VB];
      ev_addr  = aer_bus[AW-1:0];
      addr_ok  = ({1'b0, ev_addr} < N_SAT);
      acc_base = (state == CLOSE) ? '0 : acc;
      cnt_base = (state == CLOSE) ? '0 : cnt;
      ev_dup   = 1'b0;
      ev_new   = 1'b0;
      if (ev_valid && addr_ok) begin
         if (acc_base[ev_addr]) ev_dup = 1'b1;
         else                   ev_new = 1'b1;
      end
      acc_nxt = acc_base;
      cnt_nxt = cnt_base;
      if (ev_new) begin
         acc_nxt[ev_addr] = 1'b1;
         if (cnt_base != N_SAT) cnt_nxt = cnt_base + (AW+1)'(1);
      end
   end

   // Next-state logic for frame assembly.
   always_comb begin
      fall      = enable_q && !aer_enable;
      to_hit    = (frame_timeout != 0) && (to_cnt == TO_LAST);
      state_nxt = state;
      case (state)
         IDLE:    if (aer_enable || ev_valid) state_nxt = COLLECT;
         COLLECT: if (fall || to_hit)         state_nxt = CLOSE;
         CLOSE:   state_nxt = aer_enable ? COLLECT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State-derived outputs: frame hand-off strobe and timeout event.
   always_comb begin
      close_load  = (state == CLOSE);
      timeout_evt = (state == COLLECT) && to_hit;
      dbg_state   = state;
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Previous enable for edge detection and the open-frame cycle counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable_q <= 1'b0;
         to_cnt   <= '0;
      end else begin
         enable_q <= aer_enable;
         if (state == COLLECT && state_nxt == COLLECT) to_cnt <= to_cnt + TW'(1);
         else                                          to_cnt <= '0;
      end
   end

   // Spike accumulator and distinct-event count of the open frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
         cnt <= '0;
      end else begin
         acc <= acc_nxt;
         cnt <= cnt_nxt;
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_addr    <= 1'b0;
         err_dup     <= 1'b0;
         err_overrun <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (ev_valid && !addr_ok) err_addr    <= 1'b1;
         if (ev_dup)               err_dup     <= 1'b1;
         if (buf_overrun)          err_overrun <= 1'b1;
         if (timeout_evt)          err_timeout <= 1'b1;
      end
   end

   aer_frame_buffer #(
      .N  (no_of_neurons),
      .CW (AW+1)
   ) u_buf (
      .clk         (clk),
      .reset       (reset),
      .load        (close_load),
      .load_spikes (acc),
      .load_count  (cnt),
      .ready       (spikes_ready),
      .spikes      (spikes_out),
      .count       (event_count),
      .valid       (spikes_valid),
      .overrun     (buf_overrun)
   );

endmodule

// File: tb/tb_aer_decoder.sv
// Bench for aer_decoder: directed scenarios for latency, error flags,
// backpressure, timeout, frame boundary and async reset, followed by
// randomized frames checked against a set-based frame model.
module tb_aer_decoder;
   import snn_aer_pkg::*;

   localparam int N  = 10;
   localparam int AW = 4;
   localparam int TO = 8;
   localparam int EW = AW + 1 + N;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW:0]   aer_bus = '0;
   logic          aer_enable = 1'b0;
   logic [N-1:0]  spikes_out;
   logic          spikes_valid;
   logic          spikes_ready = 1'b1;
   logic [AW:0]   event_count;
   logic          err_addr, err_dup, err_overrun, err_timeout;
   aer_state_t    dbg_state;

   int            checks = 0;
   int            errors = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   aer_decoder #(
      .no_of_neurons (N),
      .frame_timeout (TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .aer_bus      (aer_bus),
      .aer_enable   (aer_enable),
      .spikes_out   (spikes_out),
      .spikes_valid (spikes_valid),
      .spikes_ready (spikes_ready),
      .event_count  (event_count),
      .err_addr     (err_addr),
      .err_dup      (err_dup),
      .err_overrun  (err_overrun),
      .err_timeout  (err_timeout),
      .dbg_state    (dbg_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Driver: present one cycle of bus/enable, return just after the edge.
   task automatic step(input logic en, input logic v, input logic [AW-1:0] a);
      aer_enable = en;
      aer_bus    = {v, a};
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int cnt, input logic [N-1:0] sp);
      exp_q.push_back({(AW+1)'(cnt), sp});
   endtask

   task automatic do_reset();
      aer_enable   = 1'b0;
      aer_bus      = '0;
      spikes_ready = 1'b1;
      reset        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Scoreboard monitor: every transferred frame must match the oldest expectation.
   always @(negedge clk) begin
      if (reset && spikes_valid && spikes_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected: got frame %0h count %0d with none expected", spikes_out, event_count);
         end else begin
            mon_e = exp_q.pop_front();
            chk("mon_spikes", 32'(spikes_out), 32'(mon_e[N-1:0]));
            chk("mon_count", 32'(event_count), 32'(mon_e[EW-1:N]));
         end
      end
   end

   // Stimulus
   initial begin
      logic [N-1:0]  set;
      int            len;
      logic          v;
      logic [AW-1:0] a;
      bit            m_addr_err;
      bit            m_dup;

      // Reset state
      #1 reset = 1'b0;
      #2;
      chk("rst_valid", 32'(spikes_valid), 0);
      chk("rst_spikes", 32'(spikes_out), 0);
      chk("rst_count", 32'(event_count), 0);
      chk("rst_flags", 32'({err_addr, err_dup, err_overrun, err_timeout}), 0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk);
      #1 reset = 1'b1;

      // Basic frame: events 3, 7, 0; valid two cycles after enable falls
      push_exp(3, 10'b00_1000_1001);
      step(1, 1, 4'd3);
      step(1, 1, 4'd7);
      step(1, 1, 4'd0);
      step(1, 0, 4'd0);
      step(0, 0, 4'd0);
      chk("basic_valid_early", 32'(spikes_valid), 0);
      chk("basic_state_close", 32'(dbg_state), 32'(CLOSE));
      step(0, 0, 4'd0);
      chk("basic_valid", 32'(spikes_valid), 1);
      chk("basic_spikes", 32'(spikes_out), 32'(10'b00_1000_1001));
      chk("basic_count", 32'(event_count), 3);
      step(0, 0, 4'd0);
      chk("basic_valid_drop", 32'(spikes_valid), 0);

      // Error flags: bad address and a duplicate
      do_reset();
      push_exp(1, 10'b00_0001_0000);
      step(1, 1, 4'd12);
      step(1, 1, 4'd4);
      step(1, 1, 4'd4);
      step(0, 0, 4'd0);
      step(0, 0, 4'd0);
      chk("err_addr", 32'(err_addr), 1);
      chk("err_dup", 32'(err_dup), 1);
      chk("err_spikes", 32'(spikes_out), 32'(10'b00_0001_0000));
      chk("err_count", 32'(event_count), 1);
      step(0, 0, 4'd0);

      // Backpressure: second frame is dropped while the first is held
      do_reset();
      spikes_ready = 1'b0;
      push_exp(1, 10'b00_0000_0010);
      step(1, 1, 4'd1);
      step(0, 0, 4'd0);
      step(0, 0, 4'd0);
      chk("bp_first_valid", 32'(spikes_valid), 1);
      step(0, 0, 4'd0);
      step(1, 1, 4'd2);
      step(0, 0, 4'd0);
      step(0, 0, 4'd0);
      chk("bp_spikes_held", 32'(spikes_out), 32'(10'b00_0000_0010));
      chk("bp_overrun", 32'(err_overrun), 1);
      chk("bp_valid_held", 32'(spikes_valid), 1);
      spikes_ready = 1'b1;
      step(0, 0, 4'd0);
      chk("bp_valid_drop", 32'(spikes_valid), 0);

      // Timeout: enable held high with one event at address 9
      do_reset();
      push_exp(1, 10'b10_0000_0000);
      push_exp(0, '0);
      step(1, 1, 4'd9);
      for (int i = 0; i < 7; i++) step(1, 0, 4'd0);
      chk("to_still_collect", 32'(dbg_state), 32'(COLLECT));
      chk("to_flag_early", 32'(err_timeout), 0);
      step(1, 0, 4'd0);
      chk("to_state_close", 32'(dbg_state), 32'(CLOSE));
      chk("to_flag", 32'(err_timeout), 1);
      step(1, 0, 4'd0);
      chk("to_valid", 32'(spikes_valid), 1);
      chk("to_spikes", 32'(spikes_out), 32'(10'b10_0000_0000));
      chk("to_reenter", 32'(dbg_state), 32'(COLLECT));
      step(0, 0, 4'd0);
      step(0, 0, 4'd0);
      chk("to_empty_valid", 32'(spikes_valid), 1);
      chk("to_empty_spikes", 32'(spikes_out), 0);
      step(0, 0, 4'd0);

      // Boundary: event 6 in the falling cycle, event 2 during CLOSE
      do_reset();
      push_exp(1, 10'b00_0100_0000);
      push_exp(1, 10'b00_0000_0100);
      step(1, 0, 4'd0);
      step(1, 0, 4'd0);
      step(0, 1, 4'd6);
      step(0, 1, 4'd2);
      chk("bnd_first_spikes", 32'(spikes_out), 32'(10'b00_0100_0000));
      chk("bnd_first_count", 32'(event_count), 1);
      step(1, 0, 4'd0);
      step(0, 0, 4'd0);
      step(0, 0, 4'd0);
      chk("bnd_second_spikes", 32'(spikes_out), 32'(10'b00_0000_0100));
      chk("bnd_second_count", 32'(event_count), 1);
      step(0, 0, 4'd0);

      // Async reset mid-frame, off a clock edge
      do_reset();
      spikes_ready = 1'b0;
      step(1, 1, 4'd7);
      step(1, 1, 4'd7);
      step(0, 0, 4'd0);
      step(0, 0, 4'd0);
      chk("ar_pre_valid", 32'(spikes_valid), 1);
      chk("ar_pre_dup", 32'(err_dup), 1);
      step(1, 1, 4'd3);
      step(1, 1, 4'd5);
      step(1, 1, 4'd8);
      #3 reset = 1'b0;
      #1;
      chk("ar_valid", 32'(spikes_valid), 0);
      chk("ar_spikes", 32'(spikes_out), 0);
      chk("ar_count", 32'(event_count), 0);
      chk("ar_flags", 32'({err_addr, err_dup, err_overrun, err_timeout}), 0);
      aer_enable = 1'b0;
      aer_bus    = '0;
      @(posedge clk);
      #1 reset = 1'b1;
      spikes_ready = 1'b1;
      push_exp(0, '0);
      step(1, 0, 4'd0);
      step(0, 0, 4'd0);
      step(0, 0, 4'd0);
      chk("ar_empty_valid", 32'(spikes_valid), 1);
      chk("ar_empty_spikes", 32'(spikes_out), 0);
      chk("ar_empty_count", 32'(event_count), 0);
      step(0, 0, 4'd0);

      // Randomized frames: expected frame is the set of in-range addresses
      // seen while enable was high plus the cycle it fell.
      do_reset();
      m_addr_err = 1'b0;
      m_dup      = 1'b0;
      for (int f = 0; f < 40; f++) begin
         set = '0;
         len = $urandom_range(1, 5);
         for (int c = 0; c <= len; c++) begin
            v = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(10, 15));
            else                           a = AW'($urandom_range(0, 9));
            if (v) begin
               if (a >= N)      m_addr_err = 1'b1;
               else if (set[a]) m_dup      = 1'b1;
               else             set[a]     = 1'b1;
            end
            spikes_ready = 1'($urandom_range(0, 1));
            step(c < len, v, a);
         end
         push_exp($countones(set), set);
         spikes_ready = 1'($urandom_range(0, 1));
         step(0, 0, 4'd0);
         spikes_ready = 1'b1;
         step(0, 0, 4'd0);
         repeat ($urandom_range(0, 2)) begin
            spikes_ready = 1'($urandom_range(0, 1));
            step(0, 0, 4'd0);
         end
      end
      chk("rnd_err_addr", 32'(err_addr), 32'(m_addr_err));
      chk("rnd_err_dup", 32'(err_dup), 32'(m_dup));
      chk("rnd_err_overrun", 32'(err_overrun), 0);
      chk("rnd_err_timeout", 32'(err_timeout), 0);

      // Report
      repeat (4) step(0, 0, 4'd0);
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
